// File: rtl/bias_accum_out.sv
// -----------------------------------------------------------------------------
// bias_accum_out
//
// Purpose:
//   Sits downstream of the bias RAM read path. It sums i_part_num partial sums
//   from the PE array for each output element. On the last part it adds the
//   bias word, arithmetic-right-shifts the total and saturates it to OUT_WIDTH.
//   Results leave as a valid-qualified stream for the output buffer.
//
//   The bias word can come from two places. One is a holding register loaded
//   ahead of time. The other is the live RAM read data ("bypass") when the word
//   arrives in the same cycle as the last part. If the last part arrives with
//   no bias available, the block parks in WAIT_BIAS until the word shows up.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous reset, active low (overrides i_calc_en)
//   i_calc_en    layer-start pulse, clears all layer state
//   i_part_num   partial sums per output element (0 behaves as 1)
//   i_shift      arithmetic right shift applied after the bias add
//   i_pe_out_en  i_pe_dat valid
//   i_pe_dat     signed partial sum
//   i_bias_vld   i_bias_dat valid
//   i_bias_dat   signed bias word
//   o_dat_vld    one-cycle result strobe
//   o_dat        shifted, saturated result (holds between strobes)
//   o_wait_bias  last part received, bias still missing
//   o_out_cnt    results emitted since the last i_calc_en
//   o_sat        sticky: a result was clamped this layer
//   o_err        sticky: protocol violation this layer
// -----------------------------------------------------------------------------
module bias_accum_out #(
    parameter int DATA_WIDTH = 16,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_calc_en,
    input  logic [7:0]            i_part_num,
    input  logic [4:0]            i_shift,
    input  logic                  i_pe_out_en,
    input  logic [DATA_WIDTH-1:0] i_pe_dat,
    input  logic                  i_bias_vld,
    input  logic [BIAS_WIDTH-1:0] i_bias_dat,
    output logic                  o_dat_vld,
    output logic [OUT_WIDTH-1:0]  o_dat,
    output logic                  o_wait_bias,
    output logic [15:0]           o_out_cnt,
    output logic                  o_sat,
    output logic                  o_err
);

    typedef enum logic [0:0] {
        ST_ACCUM     = 1'b0,
        ST_WAIT_BIAS = 1'b1
    } state_t;

    // Output clamp limits, expressed at accumulator width for comparison
    localparam logic signed [ACC_WIDTH-1:0] C_OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Stage-1 (accumulate / bias) registers
    state_t                       r_state;
    logic [7:0]                   r_pc;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [BIAS_WIDTH-1:0]        r_bh;
    logic                         r_bf;
    logic signed [ACC_WIDTH-1:0]  r_s1;
    logic                         r_s1_vld;
    logic                         r_err;

    // Stage-2 (shift / saturate) registers
    logic                         r_dat_vld;
    logic [OUT_WIDTH-1:0]         r_dat;
    logic [15:0]                  r_out_cnt;
    logic                         r_sat;

    // Next-state values for stage 1
    state_t                       w_state_nxt;
    logic [7:0]                   w_pc_nxt;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
    logic [BIAS_WIDTH-1:0]        w_bh_nxt;
    logic                         w_bf_nxt;
    logic signed [ACC_WIDTH-1:0]  w_s1_nxt;
    logic                         w_s1_vld_nxt;
    logic                         w_err_nxt;

    // Datapath helpers
    logic [7:0]                   w_part_max;
    logic                         w_last;
    logic signed [ACC_WIDTH-1:0]  w_pe_ext;
    logic signed [ACC_WIDTH-1:0]  w_bias_ext;
    logic signed [ACC_WIDTH-1:0]  w_bh_ext;
    logic signed [ACC_WIDTH-1:0]  w_part_sum;
    logic                         w_consume_bh;
    logic                         w_bypass;

    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic                         w_sat_hi;
    logic                         w_sat_lo;
    logic [OUT_WIDTH-1:0]         w_sat_dat;

    // Sign extension to accumulator width and the per-element running sum.
    // A part count of 0 behaves like 1, so every pulse is the last one.
    // The first part of an element (pc == 0) starts a fresh sum; this means
    // stale accumulator contents never need to be cleared.
    assign w_pe_ext   = {{(ACC_WIDTH-DATA_WIDTH){i_pe_dat[DATA_WIDTH-1]}}, i_pe_dat};
    assign w_bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){i_bias_dat[BIAS_WIDTH-1]}}, i_bias_dat};
    assign w_bh_ext   = {{(ACC_WIDTH-BIAS_WIDTH){r_bh[BIAS_WIDTH-1]}}, r_bh};
    assign w_part_max = (i_part_num == 8'd0) ? 8'd0 : (i_part_num - 8'd1);
    assign w_last     = (r_pc == w_part_max);
    assign w_part_sum = ((r_pc == 8'd0) ? '0 : r_acc) + w_pe_ext;

    // Next-state and datapath logic for the accumulate/bias stage.
    // The bias holding register is updated after the part handling, so the
    // same-cycle consume-plus-reload case can be seen in one place.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_acc_nxt    = r_acc;
        w_bh_nxt     = r_bh;
        w_bf_nxt     = r_bf;
        w_s1_nxt     = r_s1;
        w_s1_vld_nxt = 1'b0;
        w_err_nxt    = r_err;
        w_consume_bh = 1'b0;
        w_bypass     = 1'b0;

        case (r_state)
            ST_ACCUM: begin
                if (i_pe_out_en) begin
                    if (w_last) begin
                        w_pc_nxt = 8'd0;
                        if (r_bf) begin
                            w_s1_nxt     = w_part_sum + w_bh_ext;
                            w_s1_vld_nxt = 1'b1;
                            w_consume_bh = 1'b1;
                        end else if (i_bias_vld) begin
                            w_s1_nxt     = w_part_sum + w_bias_ext;
                            w_s1_vld_nxt = 1'b1;
                            w_bypass     = 1'b1;
                        end else begin
                            w_acc_nxt   = w_part_sum;
                            w_state_nxt = ST_WAIT_BIAS;
                        end
                    end else begin
                        w_pc_nxt  = r_pc + 8'd1;
                        w_acc_nxt = w_part_sum;
                    end
                end

                // An unconsumed word arriving on top of a held one is an
                // overwrite and is flagged. If the held word is being consumed
                // in the same cycle, the new word simply replaces it.
                if (i_bias_vld && !w_bypass) begin
                    if (r_bf && !w_consume_bh) begin
                        w_err_nxt = 1'b1;
                    end
                    w_bh_nxt = i_bias_dat;
                    w_bf_nxt = 1'b1;
                end else if (w_consume_bh) begin
                    w_bf_nxt = 1'b0;
                end
            end

            ST_WAIT_BIAS: begin
                // A new part cannot be accepted while the element is
                // incomplete. It is dropped and flagged, and pc is left alone.
                if (i_pe_out_en) begin
                    w_err_nxt = 1'b1;
                end
                if (i_bias_vld) begin
                    w_s1_nxt     = r_acc + w_bias_ext;
                    w_s1_vld_nxt = 1'b1;
                    w_state_nxt  = ST_ACCUM;
                end
            end

            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // Stage-1 state register. Both reset and the layer-start pulse wipe it,
    // and any inputs in a layer-start cycle are ignored.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_calc_en) begin
            r_state  <= ST_ACCUM;
            r_pc     <= 8'd0;
            r_acc    <= '0;
            r_bh     <= '0;
            r_bf     <= 1'b0;
            r_s1     <= '0;
            r_s1_vld <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_acc    <= w_acc_nxt;
            r_bh     <= w_bh_nxt;
            r_bf     <= w_bf_nxt;
            r_s1     <= w_s1_nxt;
            r_s1_vld <= w_s1_vld_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Shift and clamp to the signed output range
    assign w_shifted = r_s1 >>> i_shift;
    assign w_sat_hi  = (w_shifted > C_OUT_MAX);
    assign w_sat_lo  = (w_shifted < C_OUT_MIN);
    assign w_sat_dat = w_sat_hi ? C_OUT_MAX[OUT_WIDTH-1:0] :
                       w_sat_lo ? C_OUT_MIN[OUT_WIDTH-1:0] :
                                  w_shifted[OUT_WIDTH-1:0];

    // Stage-2 output register. The layer-start pulse does not stop it, so a
    // result already in stage 1 still comes out. The layer counters are still
    // cleared, and the clear takes priority over counting that result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dat_vld <= 1'b0;
            r_dat     <= '0;
            r_out_cnt <= 16'd0;
            r_sat     <= 1'b0;
        end else begin
            r_dat_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_dat <= w_sat_dat;
            end
            if (i_calc_en) begin
                r_out_cnt <= 16'd0;
                r_sat     <= 1'b0;
            end else if (r_s1_vld) begin
                r_out_cnt <= r_out_cnt + 16'd1;
                if (w_sat_hi || w_sat_lo) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign o_dat_vld   = r_dat_vld;
    assign o_dat       = r_dat;
    assign o_wait_bias = (r_state == ST_WAIT_BIAS);
    assign o_out_cnt   = r_out_cnt;
    assign o_sat       = r_sat;
    assign o_err       = r_err;

endmodule

// File: doc/bias_accum_out.md
Name: bias_accum_out

Overview:
- Downstream consumer of the bias RAM read path. Accumulates i_part_num partial sums per output element from the PE array.
- On the last part, adds the bias word read from the bias RAM, then arithmetic-right-shifts and saturates the result to OUT_WIDTH.
- Output is a valid-qualified result stream to the output buffer.
- Reuses the layer-start pulse (i_calc_en) and part-count semantics of the bias address generator.

Parameters:
- DATA_WIDTH, 16, signed width of PE partial-sum input.
- BIAS_WIDTH, 16, signed width of bias RAM read data.
- ACC_WIDTH, 32, signed accumulator width; must be >= DATA_WIDTH+8 and >= BIAS_WIDTH+1.
- OUT_WIDTH, 16, signed output width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous reset, active low.
- i_calc_en  in  1  layer-start pulse; clears all state.
- i_part_num  in  8  partial sums per output element; 0 is treated as 1.
- i_shift  in  5  arithmetic right-shift amount applied after the bias add.
- i_pe_out_en  in  1  i_pe_dat valid this cycle.
- i_pe_dat  in  DATA_WIDTH  signed partial sum.
- i_bias_vld  in  1  i_bias_dat valid (bias RAM data, one cycle after the read enable).
- i_bias_dat  in  BIAS_WIDTH  signed bias word.
- o_dat_vld  out  1  one-cycle pulse; o_dat valid.
- o_dat  out  OUT_WIDTH  shifted, saturated result.
- o_wait_bias  out  1  high while the last part has arrived and bias is absent.
- o_out_cnt  out  16  results emitted since the last i_calc_en.
- o_sat  out  1  sticky: at least one result saturated this layer.
- o_err  out  1  sticky: protocol violation this layer.

Behaviour:
- Reset (i_rst_n low at an edge): all outputs and internal registers go to 0, state is ACCUM. Reset overrides i_calc_en.
- i_calc_en: same clearing as reset, except the stage-2 pipeline still drains, so an in-flight o_dat_vld still fires. o_out_cnt, o_sat, o_err, bias holding register, part counter and accumulator are all cleared. Inputs in the same cycle are ignored.
- Part counter pc (8 bit) counts i_pe_out_en pulses from 0. A pulse is "last" when pc == max(i_part_num,1)-1. pc wraps to 0 after last.
- Accumulator: on a non-last pulse, acc <= (pc==0 ? sext(i_pe_dat) : acc + sext(i_pe_dat)). Width is ACC_WIDTH, two's complement, no saturation.
- Bias holding register bh with flag bf:
  - i_bias_vld with bf=0 and no same-cycle consumption: load bh, set bf.
  - i_bias_vld with bf=1 and no consumption this cycle: overwrite bh and set o_err.
- States:
  - ACCUM:
    - Last pulse with bf=1: consume bh. Bias source bh.
    - Last pulse with bf=0 and i_bias_vld=1: bypass-consume i_bias_dat. Bias source i_bias_dat.
    - In both cases above, stage-1 sum s1 <= (pc==0?0:acc) + sext(i_pe_dat) + sext(bias), and s1_vld <= 1. Stay in ACCUM.
    - Last pulse with no bias: acc <= final partial sum; go to WAIT_BIAS; o_wait_bias=1.
  - WAIT_BIAS:
    - i_bias_vld: s1 <= acc + sext(i_bias_dat), s1_vld <= 1; go to ACCUM; o_wait_bias falls the same edge.
    - i_pe_out_en while in WAIT_BIAS: data dropped, o_err set, pc unchanged.
  - When consumption and a new i_bias_vld coincide in ACCUM with bf=1: bh consumed, new word loads bh, bf stays 1, no error.
- Stage 2 (registered): if s1_vld, o_dat <= sat(s1 >>> i_shift) and o_dat_vld <= 1, else o_dat_vld <= 0.
  - Saturation clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sets o_sat when clamping occurs.
  - o_dat holds its value when o_dat_vld is 0.
- Latency: last part (with bias present) at edge N -> o_dat_vld high after edge N+1, for exactly one cycle. From WAIT_BIAS: i_bias_vld at edge M -> o_dat_vld after edge M+1.
- Throughput: one result per cycle when i_part_num<=1 and bias is always available.
- o_out_cnt increments with each o_dat_vld and wraps at 65535 -> 0.

Test Plan:
- Reset, then i_part_num=3, i_shift=0, bias 10 preloaded, PE data 5,-2,7 on consecutive cycles -> o_dat=20, o_dat_vld two edges after the third pulse, o_out_cnt=1.
- i_part_num=0 (treated as 1), i_shift=1, each cycle PE=100 with i_bias_vld bias=4 the same cycle, 4 cycles -> four consecutive pulses of o_dat=52, o_out_cnt=4, o_err=0.
- i_part_num=2, parts 1000,1000, no bias -> o_wait_bias=1. Bias 24 arrives 3 cycles later -> o_dat=2024 one edge after the bias cycle, o_wait_bias=0.
- i_part_num=1, OUT_WIDTH=16, PE=32767, bias=10, i_shift=0 -> o_dat=32767, o_sat=1. Then PE=-32768, bias=-5 -> o_dat=-32768.
- In WAIT_BIAS, pulse i_pe_out_en; separately, two i_bias_vld with no consumption -> o_err=1 in both cases. After i_calc_en, o_err=0, o_sat=0, o_out_cnt=0.
- Assert i_rst_n low mid-accumulation (pc=1) -> all outputs 0 after that edge. A fresh 2-part element afterwards yields the correct sum, with no residue from the aborted element.
